lab4_net_router_ctrl_rr: RTL and testbench

LAB4_NET_ROUTER_CTRL_RR -- requirements
Module: lab4_net_router_ctrl_rr

---
 rtl/lab4_net_router_ctrl_rr.sv | 180 ++++++++++++++++++
 tb/tb_lab4_net_router_ctrl_rr.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab4_net_router_ctrl_rr.sv
// Ring-router control: routes three inputs by ring distance and gives each output its own round-robin arbiter.
// Define LAB4_NET_ROUTER_CTRL_STATS_EN to build the saturating forwarded-message counter on num_fwd.
module lab4_net_router_ctrl_rr #(
    parameter int p_num_routers = 4,
    parameter int p_dest_nbits  = $clog2(p_num_routers)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [p_dest_nbits-1:0] router_id,
    input  logic                    in0_val,
    input  logic                    in1_val,
    input  logic                    in2_val,
    output logic                    in0_rdy,
    output logic                    in1_rdy,
    output logic                    in2_rdy,
    input  logic [p_dest_nbits-1:0] in0_dest,
    input  logic [p_dest_nbits-1:0] in1_dest,
    input  logic [p_dest_nbits-1:0] in2_dest,
    output logic                    out0_val,
    output logic                    out1_val,
    output logic                    out2_val,
    input  logic                    out0_rdy,
    input  logic                    out1_rdy,
    input  logic                    out2_rdy,
    output logic [1:0]              out0_sel,
    output logic [1:0]              out1_sel,
    output logic [1:0]              out2_sel,
    output logic [15:0]             num_fwd
);

    localparam logic [p_dest_nbits:0] LP_HALF = (p_dest_nbits + 1)'(p_num_routers / 2);

    function automatic logic [1:0] f_route(input logic [p_dest_nbits-1:0] dest,
                                           input logic [p_dest_nbits-1:0] id);
        logic [p_dest_nbits-1:0] d;
        d = dest - id;
        if (d == '0) begin
            return 2'd1;
        end else if ({1'b0, d} <= LP_HALF) begin
            return 2'd2;
        end else begin
            return 2'd0;
        end
    endfunction

    function automatic logic [1:0] f_mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    logic [2:0]              w_in_val;
    logic [2:0]              w_out_rdy;
    logic [p_dest_nbits-1:0] w_in_dest [3];
    logic [1:0]              w_route   [3];
    logic [2:0]              w_locked_in;
    logic [2:0]              w_req     [3];
    logic [2:0]              w_gnt_vld;
    logic [1:0]              w_gnt_idx [3];
    logic [2:0]              w_xfer;
    logic [2:0]              w_in_rdy;

    logic [1:0]              r_ptr      [3];
    logic [2:0]              r_lock;
    logic [1:0]              r_lock_idx [3];

    assign w_in_val     = {in2_val, in1_val, in0_val};
    assign w_out_rdy    = {out2_rdy, out1_rdy, out0_rdy};
    assign w_in_dest[0] = in0_dest;
    assign w_in_dest[1] = in1_dest;
    assign w_in_dest[2] = in2_dest;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_route
            assign w_route[gi] = f_route(w_in_dest[gi], router_id);
        end
    endgenerate

    always_comb begin
        logic [1:0] cand;
        cand        = 2'd0;
        w_locked_in = '0;
        w_gnt_vld   = '0;
        w_in_rdy    = '0;
        for (int j = 0; j < 3; j++) begin
            w_gnt_idx[j] = 2'd0;
            w_req[j]     = '0;
        end
        // An input held by a locked output may not be offered to any other output.
        for (int j = 0; j < 3; j++) begin
            if (r_lock[j]) begin
                w_locked_in[r_lock_idx[j]] = 1'b1;
            end
        end
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 3; k++) begin
                w_req[j][k] = w_in_val[k] && (w_route[k] == 2'(j)) && !w_locked_in[k];
            end
        end
        for (int j = 0; j < 3; j++) begin
            if (r_lock[j]) begin
                w_gnt_vld[j] = 1'b1;
                w_gnt_idx[j] = r_lock_idx[j];
            end else begin
                for (int i = 0; i < 3; i++) begin
                    cand = f_mod3_add(r_ptr[j], 2'(i));
                    if (!w_gnt_vld[j] && w_req[j][cand]) begin
                        w_gnt_vld[j] = 1'b1;
                        w_gnt_idx[j] = cand;
                    end
                end
            end
        end
        for (int j = 0; j < 3; j++) begin
            if (w_gnt_vld[j] && w_out_rdy[j]) begin
                w_in_rdy[w_gnt_idx[j]] = 1'b1;
            end
        end
    end

    assign w_xfer = w_gnt_vld & w_out_rdy;

    assign out0_val = w_gnt_vld[0] & ~reset;
    assign out1_val = w_gnt_vld[1] & ~reset;
    assign out2_val = w_gnt_vld[2] & ~reset;
    assign out0_sel = reset ? 2'd0 : w_gnt_idx[0];
    assign out1_sel = reset ? 2'd0 : w_gnt_idx[1];
    assign out2_sel = reset ? 2'd0 : w_gnt_idx[2];
    assign in0_rdy  = w_in_rdy[0] & ~reset;
    assign in1_rdy  = w_in_rdy[1] & ~reset;
    assign in2_rdy  = w_in_rdy[2] & ~reset;

    // A stalled grant is remembered so val/sel stay put until the downstream accepts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lock <= '0;
            for (int j = 0; j < 3; j++) begin
                r_ptr[j]      <= 2'd0;
                r_lock_idx[j] <= 2'd0;
            end
        end else begin
            for (int j = 0; j < 3; j++) begin
                if (w_xfer[j]) begin
                    r_ptr[j]  <= f_mod3_add(w_gnt_idx[j], 2'd1);
                    r_lock[j] <= 1'b0;
                end else if (w_gnt_vld[j]) begin
                    r_lock[j]     <= 1'b1;
                    r_lock_idx[j] <= w_gnt_idx[j];
                end else begin
                    r_lock[j] <= 1'b0;
                end
            end
        end
    end

`ifdef LAB4_NET_ROUTER_CTRL_STATS_EN
    logic [15:0] r_num_fwd;
    logic [16:0] w_fwd_sum;

    assign w_fwd_sum = {1'b0, r_num_fwd} + 17'(w_xfer[0]) + 17'(w_xfer[1]) + 17'(w_xfer[2]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num_fwd <= 16'd0;
        end else if (w_fwd_sum > 17'h0FFFF) begin
            r_num_fwd <= 16'hFFFF;
        end else begin
            r_num_fwd <= w_fwd_sum[15:0];
        end
    end

    assign num_fwd = r_num_fwd;
`else
    assign num_fwd = 16'd0;
`endif

endmodule

// File: tb/tb_lab4_net_router_ctrl_rr.sv
// Bench for lab4_net_router_ctrl_rr: directed literal cases plus randomized traffic against a behavioural model.
module tb_lab4_net_router_ctrl_rr;

    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic [1:0] router_id;
    logic [2:0] in_val;
    logic [1:0] in_dest [3];
    logic [2:0] out_rdy;
    wire  [2:0] in_rdy;
    wire  [2:0] out_val;
    wire  [1:0] out_sel [3];
    wire  [15:0] num_fwd;

    logic [2:0] in8_val;
    logic [2:0] in8_dest [3];
    logic [2:0] out8_rdy;
    wire  [2:0] in8_rdy;
    wire  [2:0] out8_val;
    wire  [1:0] out8_sel [3];
    wire  [15:0] num8_fwd;
    logic [2:0] router8_id;

    int checks = 0;
    int errors = 0;

    // model state: last input served per output, input held by a stalled output (-1 none)
    int m_last [3];
    int m_held [3];
    int m_fwd;

    lab4_net_router_ctrl_rr #(.p_num_routers(N)) u_dut (
        .clk(clk), .reset(rst), .router_id(router_id),
        .in0_val(in_val[0]), .in1_val(in_val[1]), .in2_val(in_val[2]),
        .in0_rdy(in_rdy[0]), .in1_rdy(in_rdy[1]), .in2_rdy(in_rdy[2]),
        .in0_dest(in_dest[0]), .in1_dest(in_dest[1]), .in2_dest(in_dest[2]),
        .out0_val(out_val[0]), .out1_val(out_val[1]), .out2_val(out_val[2]),
        .out0_rdy(out_rdy[0]), .out1_rdy(out_rdy[1]), .out2_rdy(out_rdy[2]),
        .out0_sel(out_sel[0]), .out1_sel(out_sel[1]), .out2_sel(out_sel[2]),
        .num_fwd(num_fwd)
    );

    lab4_net_router_ctrl_rr #(.p_num_routers(8)) u_dut8 (
        .clk(clk), .reset(rst), .router_id(router8_id),
        .in0_val(in8_val[0]), .in1_val(in8_val[1]), .in2_val(in8_val[2]),
        .in0_rdy(in8_rdy[0]), .in1_rdy(in8_rdy[1]), .in2_rdy(in8_rdy[2]),
        .in0_dest(in8_dest[0]), .in1_dest(in8_dest[1]), .in2_dest(in8_dest[2]),
        .out0_val(out8_val[0]), .out1_val(out8_val[1]), .out2_val(out8_val[2]),
        .out0_rdy(out8_rdy[0]), .out1_rdy(out8_rdy[1]), .out2_rdy(out8_rdy[2]),
        .out0_sel(out8_sel[0]), .out1_sel(out8_sel[1]), .out2_sel(out8_sel[2]),
        .num_fwd(num8_fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int route_of(input int dest, input int id);
        int d;
        d = (dest - id + N) % N;
        if (d == 0) return 1;
        if (d <= N / 2) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 3; j++) begin
            m_last[j] = 2;
            m_held[j] = -1;
        end
        m_fwd = 0;
    endtask

    // Reset with every input active to show outputs stay quiet during reset.
    task automatic do_reset(input int id);
        @(negedge clk);
        rst       = 1'b1;
        router_id = 2'(id);
        in_val    = 3'b111;
        out_rdy   = 3'b111;
        for (int k = 0; k < 3; k++) in_dest[k] = 2'(id);
        #1;
        chk("reset_out_val", int'(out_val), 0);
        chk("reset_in_rdy", int'(in_rdy), 0);
        @(negedge clk);
        chk("reset_num_fwd", int'(num_fwd), 0);
        in_val  = 3'b000;
        out_rdy = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic random_phase(input int id, input int ncyc);
        logic [2:0] drop;
        int grant [3];
        bit taken [3];
        int exp_sel;
        logic [2:0] exp_val;
        logic [2:0] exp_rdy;
        do_reset(id);
        drop = 3'b000;
        for (int c = 0; c < ncyc; c++) begin
            if (c != 0) @(negedge clk);
            in_val = in_val & ~drop;
            for (int k = 0; k < 3; k++) begin
                if (!in_val[k] && $urandom_range(0, 9) < 6) begin
                    in_val[k]  = 1'b1;
                    in_dest[k] = 2'($urandom_range(0, N - 1));
                end
            end
            for (int j = 0; j < 3; j++) out_rdy[j] = ($urandom_range(0, 9) < 7);
            #1;
            for (int k = 0; k < 3; k++) taken[k] = 0;
            for (int j = 0; j < 3; j++) if (m_held[j] >= 0) taken[m_held[j]] = 1;
            exp_val = 3'b000;
            exp_rdy = 3'b000;
            for (int j = 0; j < 3; j++) begin
                grant[j] = m_held[j];
                if (grant[j] < 0) begin
                    for (int s = 1; s <= 3 && grant[j] < 0; s++) begin
                        int k;
                        k = (m_last[j] + s) % 3;
                        if (in_val[k] && !taken[k] && route_of(int'(in_dest[k]), id) == j) grant[j] = k;
                    end
                end
                if (grant[j] >= 0) begin
                    exp_val[j] = 1'b1;
                    if (out_rdy[j]) exp_rdy[grant[j]] = 1'b1;
                end
                exp_sel = (grant[j] >= 0) ? grant[j] : 0;
                chk($sformatf("rnd_sel%0d_c%0d", j, c), int'(out_sel[j]), exp_sel);
            end
            chk($sformatf("rnd_out_val_c%0d", c), int'(out_val), int'(exp_val));
            chk($sformatf("rnd_in_rdy_c%0d", c), int'(in_rdy), int'(exp_rdy));
            chk($sformatf("rnd_num_fwd_c%0d", c), int'(num_fwd), m_fwd);
            for (int j = 0; j < 3; j++) begin
                if (grant[j] >= 0 && out_rdy[j]) begin
                    $display("xfer id=%0d cyc=%0d out%0d <- in%0d dest=%0d", id, c, j, grant[j], in_dest[grant[j]]);
                    m_last[j] = grant[j];
                    m_held[j] = -1;
`ifdef LAB4_NET_ROUTER_CTRL_STATS_EN
                    if (m_fwd < 65535) m_fwd++;
`endif
                end else begin
                    m_held[j] = grant[j];
                end
            end
            drop = exp_rdy;
        end
    endtask

    initial begin
        rst        = 1'b1;
        router_id  = 2'd0;
        in_val     = 3'b000;
        out_rdy    = 3'b000;
        for (int k = 0; k < 3; k++) in_dest[k] = 2'd0;
        router8_id = 3'd0;
        in8_val    = 3'b000;
        out8_rdy   = 3'b111;
        for (int k = 0; k < 3; k++) in8_dest[k] = 3'd0;

        // single terminal delivery, same cycle
        do_reset(1);
        in_val = 3'b010; in_dest[1] = 2'd1; out_rdy = 3'b010;
        #1;
        chk("t1_out1_val", int'(out_val[1]), 1);
        chk("t1_out1_sel", int'(out_sel[1]), 1);
        chk("t1_in1_rdy", int'(in_rdy[1]), 1);
        chk("t1_other_val", int'({out_val[2], out_val[0]}), 0);
        $display("t1 terminal delivery checked");

        // three inputs contending for out1: grants rotate 0,1,2 then back to 0
        do_reset(1);
        in_val = 3'b111; out_rdy = 3'b010;
        for (int k = 0; k < 3; k++) in_dest[k] = 2'd1;
        for (int c = 0; c < 4; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            chk($sformatf("t2_sel_c%0d", c), int'(out_sel[1]), c % 3);
            chk($sformatf("t2_in_rdy_c%0d", c), int'(in_rdy), 1 << (c % 3));
            $display("t2 cycle %0d grant checked", c);
        end

        // stall on out2 keeps in0 locked; after transfer in2 wins
        do_reset(1);
        in_val = 3'b101; in_dest[0] = 2'd2; in_dest[2] = 2'd3; out_rdy = 3'b000;
        for (int c = 0; c < 3; c++) begin
            if (c != 0) @(negedge clk);
            if (c == 2) out_rdy = 3'b100;
            #1;
            chk($sformatf("t3_sel_c%0d", c), int'(out_sel[2]), 0);
            chk($sformatf("t3_val_c%0d", c), int'(out_val[2]), 1);
            chk($sformatf("t3_rdy_c%0d", c), int'(in_rdy), (c == 2) ? 1 : 0);
        end
        @(negedge clk);
        #1;
        chk("t3_next_sel", int'(out_sel[2]), 2);
        $display("t3 stall and rotation checked");

        // reset while locked on in2 with pointer at 1
        do_reset(1);
        in_val = 3'b101; in_dest[0] = 2'd2; in_dest[2] = 2'd3; out_rdy = 3'b100;
        #1;
        chk("t4_first_sel", int'(out_sel[2]), 0);
        @(negedge clk);
        out_rdy = 3'b000;
        #1;
        chk("t4_lock_sel", int'(out_sel[2]), 2);
        @(negedge clk);
        #1;
        chk("t4_lock_hold", int'(out_sel[2]), 2);
        rst = 1'b1;
        #1;
        chk("t4_rst_val", int'(out_val), 0);
        chk("t4_rst_rdy", int'(in_rdy), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t4_after_sel", int'(out_sel[2]), 0);
        chk("t4_after_fwd", int'(num_fwd), 0);
        $display("t4 reset mid-lock checked");

        // eight-router ring routing
        @(negedge clk);
        in8_val = 3'b010; in8_dest[1] = 3'd4;
        #1;
        chk("t5_d4_val", int'(out8_val), 3'b100);
        chk("t5_d4_sel", int'(out8_sel[2]), 1);
        @(negedge clk);
        in8_dest[1] = 3'd5;
        #1;
        chk("t5_d5_val", int'(out8_val), 3'b001);
        chk("t5_d5_sel", int'(out8_sel[0]), 1);
        @(negedge clk);
        in8_dest[1] = 3'd3;
        #1;
        chk("t5_d3_val", int'(out8_val), 3'b100);
        chk("t5_d3_sel", int'(out8_sel[2]), 1);
        @(negedge clk);
        in8_val = 3'b000;
        $display("t5 ring routing checked");

        random_phase(2, 1500);
        random_phase(3, 1500);

`ifdef LAB4_NET_ROUTER_CTRL_STATS_EN
        // three parallel transfers per cycle until the counter saturates
        do_reset(1);
        in_val = 3'b111; in_dest[0] = 2'd0; in_dest[1] = 2'd1; in_dest[2] = 2'd2; out_rdy = 3'b111;
        repeat (10) @(negedge clk);
        chk("t6_count30", int'(num_fwd), 30);
        repeat (21836) @(negedge clk);
        chk("t6_saturated", int'(num_fwd), 65535);
        repeat (3) @(negedge clk);
        chk("t6_holds", int'(num_fwd), 65535);
        $display("t6 saturation checked");
`else
        do_reset(1);
        in_val = 3'b111; in_dest[0] = 2'd0; in_dest[1] = 2'd1; in_dest[2] = 2'd2; out_rdy = 3'b111;
        repeat (5) @(negedge clk);
        chk("t6_no_stats", int'(num_fwd), 0);
        $display("t6 stats disabled checked");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
